// File: rtl/spi_flash_reader_if.sv
// Bundle of the command handshake, read-back port and PROM pins of spi_flash_reader.
// The slave modport is the reader itself. The master modport is its environment,
// which is the user logic plus the PROM's SPIMISO pin.
`timescale 1ns/1ps
interface spi_flash_reader_if #(
  parameter int LEN_W = 3,
  parameter int SEL_W = 2
);
  logic             start;
  logic [7:0]       opcode;
  logic             addr_en;
  logic [23:0]      addr;
  logic [LEN_W-1:0] rd_len;
  logic [SEL_W-1:0] sel;
  logic [7:0]       rd_data;
  logic             busy;
  logic             done;
  logic             SPICLK;
  logic             SPIMOSI;
  logic             SPIMISO;
  logic             cs_prom_n;

  modport master (
    output start, opcode, addr_en, addr, rd_len, sel, SPIMISO,
    input  rd_data, busy, done, SPICLK, SPIMOSI, cs_prom_n
  );

  modport slave (
    input  start, opcode, addr_en, addr, rd_len, sel, SPIMISO,
    output rd_data, busy, done, SPICLK, SPIMOSI, cs_prom_n
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 command engine for the M25P16 PROM.
// It sends an opcode and an optional 24-bit address, then clocks in up to
// MAX_BYTES response bytes into a buffer that the user logic reads by index.
//
// state | meaning
// IDLE  | chip deselected, waiting for start
// SETUP | CS low, opcode bit 7 on MOSI, one half-period before first rise
// SHIFT | opcode, address and read bytes, MSB first
// HOLD  | SPICLK low, CS still low for one half-period
// DESEL | CS high for two half-periods (tSHSL); done pulses on entry
`timescale 1ns/1ps
module spi_flash_reader #(
  parameter int CLK_DIV   = 1,
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1),
  parameter int SEL_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input logic               clk,
  input logic               reset,
  spi_flash_reader_if.slave bus
);
  localparam int CNT_W  = $clog2(2 * CLK_DIV) + 1;
  localparam int BYTE_W = $clog2(MAX_BYTES + 5);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DESEL_LOAD = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DESEL} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] byte_idx;
  logic [BYTE_W-1:0] nbytes;
  logic [7:0]        op_q;
  logic              aen_q;
  logic [23:0]       addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        rx_sr;
  logic [7:0]        data_buf [MAX_BYTES];
  logic              sclk, mosi, cs_n, busy, done;

  logic [LEN_W-1:0]  len_clamp;
  logic [BYTE_W-1:0] hdr;
  logic [BYTE_W-1:0] wr_idx;
  logic              is_rd;
  logic [7:0]        rx_next;
  logic [7:0]        cur_tx;
  logic [7:0]        nxt_tx;
  logic [SEL_W-1:0]  sel_v;

  // Byte sent at position idx. Read-phase positions send zero.
  function automatic logic [7:0] tx_byte(input logic [BYTE_W-1:0] idx, input logic [7:0] op,
                                         input logic aen, input logic [23:0] a);
    logic [7:0] b;
    b = 8'h00;
    if (idx == '0)                         b = op;
    else if (aen && idx == BYTE_W'(1))     b = a[23:16];
    else if (aen && idx == BYTE_W'(2))     b = a[15:8];
    else if (aen && idx == BYTE_W'(3))     b = a[7:0];
    return b;
  endfunction

  assign len_clamp = (bus.rd_len > MAX_LEN) ? MAX_LEN : bus.rd_len;
  assign hdr       = aen_q ? BYTE_W'(4) : BYTE_W'(1);
  assign is_rd     = (byte_idx >= hdr);
  assign wr_idx    = byte_idx - hdr;
  assign rx_next   = {rx_sr[6:0], bus.SPIMISO};
  assign sel_v     = bus.sel;

  assign bus.SPICLK    = sclk;
  assign bus.SPIMOSI   = mosi;
  assign bus.cs_prom_n = cs_n;
  assign bus.busy      = busy;
  assign bus.done      = done;

  // Current and following transmit bytes, so MOSI is ready at each falling edge.
  always_comb begin
    cur_tx = tx_byte(byte_idx, op_q, aen_q, addr_q);
    nxt_tx = tx_byte(byte_idx + 1'b1, op_q, aen_q, addr_q);
  end

  // Read-back mux. Entries at or beyond the latched length read as 0xFF.
  always_comb begin
    bus.rd_data = 8'hFF;
    for (int i = 0; i < MAX_BYTES; i++)
      if (sel_v == SEL_W'(i) && LEN_W'(i) < len_q) bus.rd_data = data_buf[i];
  end

  // Transaction sequencer. All pin and status outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      nbytes   <= '0;
      op_q     <= '0;
      aen_q    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      rx_sr    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) data_buf[i] <= 8'hFF;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.opcode;
            aen_q    <= bus.addr_en;
            addr_q   <= bus.addr;
            len_q    <= len_clamp;
            nbytes   <= BYTE_W'(1) + (bus.addr_en ? BYTE_W'(3) : BYTE_W'(0)) + BYTE_W'(len_clamp);
            byte_idx <= '0;
            bit_idx  <= 3'd7;
            cnt      <= HALF_LOAD;
            mosi     <= bus.opcode[7];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            for (int i = 0; i < MAX_BYTES; i++) data_buf[i] <= 8'hFF;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            cnt   <= HALF_LOAD;
            state <= SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= HALF_LOAD;
            if (!sclk) begin
              sclk  <= 1'b1;
              rx_sr <= rx_next;
              if (bit_idx == 3'd0)
                for (int i = 0; i < MAX_BYTES; i++)
                  if (is_rd && wr_idx == BYTE_W'(i)) data_buf[i] <= rx_next;
            end else begin
              sclk <= 1'b0;
              if (bit_idx != 3'd0) begin
                bit_idx <= bit_idx - 1'b1;
                mosi    <= cur_tx[bit_idx - 3'd1];
              end else if (byte_idx == nbytes - 1'b1) begin
                mosi  <= 1'b0;
                state <= HOLD;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                bit_idx  <= 3'd7;
                mosi     <= nxt_tx[7];
              end
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cs_n  <= 1'b1;
            done  <= 1'b1;
            cnt   <= DESEL_LOAD;
            state <= DESEL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DESEL: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader. There are two instances: CLK_DIV=1 and
// CLK_DIV=4, both with MAX_BYTES=4. A small behavioural M25P16 model answers
// each instance.
`timescale 1ns/1ps
module tb_spi_flash_reader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_flash_reader_if #(.LEN_W(3), .SEL_W(2)) bus_a ();
  spi_flash_reader_if #(.LEN_W(3), .SEL_W(2)) bus_b ();

  spi_flash_reader #(.CLK_DIV(1), .MAX_BYTES(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  spi_flash_reader #(.CLK_DIV(4), .MAX_BYTES(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  int vectors = 0;
  int miscompares = 0;

  // PROM model state, one slot per instance
  logic       miso_v [2] = '{1'b0, 1'b0};
  logic       sck_q  [2] = '{1'b0, 1'b0};
  logic       cs_q   [2] = '{1'b1, 1'b1};
  int         rises  [2] = '{0, 0};
  int         nbit   [2] = '{0, 0};
  logic [7:0] sh     [2] = '{8'h00, 8'h00};
  logic [7:0] rxb    [2][4];
  int         rise_cyc [2][2];
  int         cyc = 0;
  logic       sck_v, csn_v, mosi_v;

  assign bus_a.SPIMISO = miso_v[0];
  assign bus_b.SPIMISO = miso_v[1];

  function automatic logic [7:0] rdid_byte(input int i);
    case (i)
      0: return 8'h20;
      1: return 8'h20;
      2: return 8'h15;
      3: return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a[2:0])
      3'd0: return 8'h5A;
      3'd1: return 8'h6B;
      3'd2: return 8'h7C;
      3'd3: return 8'h8D;
      3'd4: return 8'h9E;
      3'd5: return 8'hAF;
      3'd6: return 8'hC0;
      default: return 8'hD1;
    endcase
  endfunction

  function automatic logic model_bit(input logic [7:0] cmd, input logic [23:0] adr, input int n);
    logic [7:0] d;
    d = 8'h00;
    if (cmd == 8'h9F && n >= 8)       d = rdid_byte((n - 8) / 8);
    else if (cmd == 8'h03 && n >= 32) d = mem_byte(adr + 24'((n - 32) / 8));
    return d[3'(7 - n % 8)];
  endfunction

  // PROM model: it samples MOSI on SPICLK rise and drives MISO after SPICLK fall.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      sck_v  = d ? bus_b.SPICLK    : bus_a.SPICLK;
      csn_v  = d ? bus_b.cs_prom_n : bus_a.cs_prom_n;
      mosi_v = d ? bus_b.SPIMOSI   : bus_a.SPIMOSI;
      if (csn_v) begin
        miso_v[d] = 1'b0;
      end else begin
        if (cs_q[d]) begin
          nbit[d] = 0;
          rises[d] = 0;
          for (int k = 0; k < 4; k++) rxb[d][k] = 8'h00;
        end
        if (sck_v && !sck_q[d]) begin
          sh[d] = {sh[d][6:0], mosi_v};
          nbit[d]++;
          rises[d]++;
          if (rises[d] <= 2) rise_cyc[d][rises[d]-1] = cyc;
          if (nbit[d] % 8 == 0 && nbit[d] <= 32) rxb[d][nbit[d]/8 - 1] = sh[d];
        end
        if (!sck_v && sck_q[d])
          miso_v[d] = model_bit(rxb[d][0], {rxb[d][1], rxb[d][2], rxb[d][3]}, nbit[d]);
      end
      sck_q[d] = sck_v;
      cs_q[d]  = csn_v;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input int d, input logic [1:0] s, input logic [7:0] exp, input string tag);
    if (d == 0) bus_a.sel = s; else bus_b.sel = s;
    #1;
    chk(tag, d ? bus_b.rd_data : bus_a.rd_data, exp);
  endtask

  // Issues one command. It returns the done and busy-low latencies in cycles after
  // the accept edge, plus cs_prom_n on the done cycle. inj_k > 0 pulses a
  // competing RDSR start k cycles in.
  task automatic run(input int d, input logic [7:0] op, input logic aen, input logic [23:0] ad,
                     input logic [2:0] len, input int inj_k,
                     output int done_lat, output int idle_lat, output logic cs_done);
    logic dn, bz;
    done_lat = -1; idle_lat = -1; cs_done = 1'bx;
    @(negedge clk);
    if (d == 0) begin
      bus_a.opcode = op; bus_a.addr_en = aen; bus_a.addr = ad; bus_a.rd_len = len; bus_a.start = 1'b1;
    end else begin
      bus_b.opcode = op; bus_b.addr_en = aen; bus_b.addr = ad; bus_b.rd_len = len; bus_b.start = 1'b1;
    end
    @(posedge clk); #1;
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (k == inj_k) begin
        if (d == 0) begin
          bus_a.opcode = 8'h05; bus_a.addr_en = 1'b1; bus_a.rd_len = 3'd1; bus_a.start = 1'b1;
        end else begin
          bus_b.opcode = 8'h05; bus_b.addr_en = 1'b1; bus_b.rd_len = 3'd1; bus_b.start = 1'b1;
        end
      end else begin
        bus_a.start = 1'b0; bus_b.start = 1'b0;
      end
      dn = d ? bus_b.done : bus_a.done;
      bz = d ? bus_b.busy : bus_a.busy;
      if (done_lat < 0 && dn) begin
        done_lat = k;
        cs_done = d ? bus_b.cs_prom_n : bus_a.cs_prom_n;
      end
      if (done_lat >= 0 && !bz) begin
        idle_lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int   dl, il, k2;
  logic csd, hit;

  initial begin
    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.opcode = '0; bus_a.addr_en = 1'b0; bus_a.addr = '0; bus_a.rd_len = '0; bus_a.sel = '0;
    bus_b.start = 1'b0; bus_b.opcode = '0; bus_b.addr_en = 1'b0; bus_b.addr = '0; bus_b.rd_len = '0; bus_b.sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs",   bus_a.cs_prom_n, 1);
    chk("rst_sclk", bus_a.SPICLK, 0);
    chk("rst_mosi", bus_a.SPIMOSI, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_data", bus_a.rd_data, 8'hFF);
    @(negedge clk) reset = 1'b0;

    // RDID, CLK_DIV=1
    run(0, 8'h9F, 1'b0, 24'h0, 3'd3, -1, dl, il, csd);
    chk("rdid_done_lat", dl, 67);
    chk("rdid_idle_lat", il, 69);
    chk("rdid_cs_at_done", csd, 1);
    chk("rdid_rises", rises[0], 32);
    chk("rdid_opcode_tx", rxb[0][0], 8'h9F);
    rd_chk(0, 2'd0, 8'h20, "rdid_sel0");
    rd_chk(0, 2'd1, 8'h20, "rdid_sel1");
    rd_chk(0, 2'd2, 8'h15, "rdid_sel2");
    rd_chk(0, 2'd3, 8'hFF, "rdid_sel3");

    // WREN, command only
    run(0, 8'h06, 1'b0, 24'h0, 3'd0, -1, dl, il, csd);
    chk("wren_done_lat", dl, 19);
    chk("wren_idle_lat", il, 21);
    chk("wren_rises", rises[0], 8);
    chk("wren_opcode_tx", rxb[0][0], 8'h06);
    rd_chk(0, 2'd0, 8'hFF, "wren_sel0");
    rd_chk(0, 2'd3, 8'hFF, "wren_sel3");

    // rd_len clamp plus ignored start mid-SHIFT
    run(0, 8'h9F, 1'b0, 24'h0, 3'd7, 20, dl, il, csd);
    chk("clamp_done_lat", dl, 83);
    chk("clamp_rises", rises[0], 40);
    chk("clamp_opcode_tx", rxb[0][0], 8'h9F);
    chk("clamp_byte1_tx", rxb[0][1], 8'h00);
    rd_chk(0, 2'd0, 8'h20, "clamp_sel0");
    rd_chk(0, 2'd1, 8'h20, "clamp_sel1");
    rd_chk(0, 2'd2, 8'h15, "clamp_sel2");
    rd_chk(0, 2'd3, 8'h10, "clamp_sel3");

    // Reset at bit 12 of RDID
    bus_a.sel = 2'd0;
    @(negedge clk);
    bus_a.opcode = 8'h9F; bus_a.addr_en = 1'b0; bus_a.rd_len = 3'd3; bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rises[0] >= 12) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("midrst_reached_bit12", hit, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_cs",   bus_a.cs_prom_n, 1);
    chk("midrst_sclk", bus_a.SPICLK, 0);
    chk("midrst_busy", bus_a.busy, 0);
    chk("midrst_data", bus_a.rd_data, 8'hFF);
    @(negedge clk) reset = 1'b0;
    run(0, 8'h9F, 1'b0, 24'h0, 3'd3, -1, dl, il, csd);
    chk("fresh_done_lat", dl, 67);

    // Back-to-back: start on the first cycle busy is low
    bus_a.opcode = 8'h9F; bus_a.addr_en = 1'b0; bus_a.rd_len = 3'd3; bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    chk("b2b_busy", bus_a.busy, 1);
    chk("b2b_cs", bus_a.cs_prom_n, 0);
    k2 = -1;
    for (int k = 1; k <= 500; k++) begin
      if (!bus_a.busy) begin
        k2 = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_idle_lat", k2, 69);
    rd_chk(0, 2'd0, 8'h20, "b2b_sel0");
    rd_chk(0, 2'd1, 8'h20, "b2b_sel1");
    rd_chk(0, 2'd2, 8'h15, "b2b_sel2");

    // READ from address 0, CLK_DIV=4
    run(1, 8'h03, 1'b1, 24'h000000, 3'd4, -1, dl, il, csd);
    chk("read_done_lat", dl, 521);
    chk("read_idle_lat", il, 529);
    chk("read_rises", rises[1], 64);
    chk("read_sclk_period", rise_cyc[1][1] - rise_cyc[1][0], 8);
    chk("read_tx0", rxb[1][0], 8'h03);
    chk("read_tx1", rxb[1][1], 8'h00);
    chk("read_tx2", rxb[1][2], 8'h00);
    chk("read_tx3", rxb[1][3], 8'h00);
    rd_chk(1, 2'd0, 8'h5A, "read_sel0");
    rd_chk(1, 2'd1, 8'h6B, "read_sel1");
    rd_chk(1, 2'd2, 8'h7C, "read_sel2");
    rd_chk(1, 2'd3, 8'h8D, "read_sel3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
